// File: rtl/cpu_pkg.sv
// Shared definitions for the RAM port arbiter.
//   - port index constants (fetch, data, debug) used to index req/we/gnt/done
//   - arbiter FSM state encoding
//   - small helpers for aging counters and one-hot/index conversion
package cpu_pkg;

  localparam int unsigned PORT_FETCH = 0;
  localparam int unsigned PORT_DATA  = 1;
  localparam int unsigned PORT_DBG   = 2;
  localparam int unsigned NUM_PORTS  = 3;

  // Aging counters are sized for the largest allowed starvation limit.
  localparam int unsigned AGE_W = 8;

  typedef enum logic {
    IDLE,
    ACCESS
  } arb_state_e;

  // Next value of an aging counter for one IDLE cycle.
  function automatic logic [AGE_W-1:0] age_next(input logic [AGE_W-1:0] age,
                                                input logic             req_bit,
                                                input logic             gnt_bit,
                                                input logic [AGE_W-1:0] limit);
    if (!req_bit || gnt_bit) begin
      return '0;
    end else if (age < limit) begin
      return age + 1'b1;
    end else begin
      return age;
    end
  endfunction

  function automatic logic [1:0] oh_to_idx(input logic [NUM_PORTS-1:0] oh);
    if (oh[PORT_DBG]) begin
      return 2'd2;
    end else if (oh[PORT_DATA]) begin
      return 2'd1;
    end else begin
      return 2'd0;
    end
  endfunction

  function automatic logic [NUM_PORTS-1:0] idx_to_oh(input logic [1:0] idx);
    return 3'b001 << idx;
  endfunction

endpackage

// File: rtl/arb_prio_age.sv
// Winner select for the RAM port arbiter with anti-starvation aging.
// Fixed priority data > fetch > debug, except that a fetch or debug port whose
// aging counter has reached STARVE_LIMIT is promoted above data (fetch first).
// Ports:
//   CLK, Reset  clock (rising edge) and synchronous active-high reset
//   req         per-port request (bit0 fetch, bit1 data, bit2 debug)
//   idle        arbiter FSM is in IDLE; grants and counter updates only then
//   gnt         one-hot grant, zero outside IDLE
module arb_prio_age
  import cpu_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic                 CLK,
  input  logic                 Reset,
  input  logic [NUM_PORTS-1:0] req,
  input  logic                 idle,
  output logic [NUM_PORTS-1:0] gnt
);

  localparam logic [AGE_W-1:0] Limit = AGE_W'(STARVE_LIMIT);

  logic [AGE_W-1:0] age_f_q, age_f_d;
  logic [AGE_W-1:0] age_g_q, age_g_d;
  logic             promo_f, promo_g;
  logic [NUM_PORTS-1:0] winner;

  always_comb begin
    // Gate with req so a counter left at the limit by a just-dropped request
    // cannot grant an absent port.
    promo_f = req[PORT_FETCH] && (age_f_q == Limit);
    promo_g = req[PORT_DBG] && (age_g_q == Limit);

    winner = '0;
    if (promo_f) begin
      winner[PORT_FETCH] = 1'b1;
    end else if (promo_g) begin
      winner[PORT_DBG] = 1'b1;
    end else if (req[PORT_DATA]) begin
      winner[PORT_DATA] = 1'b1;
    end else if (req[PORT_FETCH]) begin
      winner[PORT_FETCH] = 1'b1;
    end else if (req[PORT_DBG]) begin
      winner[PORT_DBG] = 1'b1;
    end

    gnt = idle ? winner : '0;
  end

  always_comb begin
    age_f_d = age_f_q;
    age_g_d = age_g_q;
    if (idle) begin
      age_f_d = age_next(age_f_q, req[PORT_FETCH], gnt[PORT_FETCH], Limit);
      age_g_d = age_next(age_g_q, req[PORT_DBG], gnt[PORT_DBG], Limit);
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      age_f_q <= '0;
      age_g_q <= '0;
    end else begin
      age_f_q <= age_f_d;
      age_g_q <= age_g_d;
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares the single-ported data RAM between fetch, data (LDUR/STUR) and
// debug/loader requesters. One access at a time: grant in IDLE, hold the RAM
// strobes for MEM_LAT cycles in ACCESS, then pulse done for one cycle.
// Ports:
//   CLK, Reset                 clock (rising edge), synchronous active-high reset
//   req, we                    per-port request and write flag (bit0 fetch,
//                              bit1 data, bit2 debug; fetch is read-only)
//   addr_f, addr_d, addr_g     per-port address
//   wdata_d, wdata_g           write data for data and debug ports
//   gnt                        one-hot grant (combinational, IDLE only)
//   done                       one-hot one-cycle completion pulse
//   rdata                      read data, valid with done
//   busy                       access in progress
//   mem_cs/mem_wr/mem_rd       RAM strobes
//   mem_addr, mem_wdata        RAM address and write data
//   mem_rdata                  RAM read data, valid on the last strobe cycle
module ram_port_arbiter
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W       = 16,
  parameter int unsigned DATA_W       = 64,
  parameter int unsigned MEM_LAT      = 2,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic                 CLK,
  input  logic                 Reset,
  input  logic [NUM_PORTS-1:0] req,
  input  logic [NUM_PORTS-1:0] we,
  input  logic [ADDR_W-1:0]    addr_f,
  input  logic [ADDR_W-1:0]    addr_d,
  input  logic [ADDR_W-1:0]    addr_g,
  input  logic [DATA_W-1:0]    wdata_d,
  input  logic [DATA_W-1:0]    wdata_g,
  output logic [NUM_PORTS-1:0] gnt,
  output logic [NUM_PORTS-1:0] done,
  output logic [DATA_W-1:0]    rdata,
  output logic                 busy,
  output logic                 mem_cs,
  output logic                 mem_wr,
  output logic                 mem_rd,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [DATA_W-1:0]    mem_wdata,
  input  logic [DATA_W-1:0]    mem_rdata
);

  localparam logic [3:0] CntInit = 4'(MEM_LAT - 1);

  arb_state_e           state_q, state_d;
  logic [3:0]           count_q, count_d;
  logic [1:0]           acc_id_q, acc_id_d;
  logic                 acc_we_q, acc_we_d;
  logic [ADDR_W-1:0]    acc_addr_q, acc_addr_d;
  logic [DATA_W-1:0]    acc_wdata_q, acc_wdata_d;
  logic [DATA_W-1:0]    rdata_q, rdata_d;
  logic [NUM_PORTS-1:0] done_q, done_d;
  logic                 idle;

  // The fetch port never writes; its write flag is intentionally ignored.
  logic unused_we_fetch;
  assign unused_we_fetch = we[PORT_FETCH];

  assign idle = (state_q == IDLE);

  arb_prio_age #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_arb (
    .CLK  (CLK),
    .Reset(Reset),
    .req  (req),
    .idle (idle),
    .gnt  (gnt)
  );

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    acc_id_d    = acc_id_q;
    acc_we_d    = acc_we_q;
    acc_addr_d  = acc_addr_q;
    acc_wdata_d = acc_wdata_q;
    rdata_d     = rdata_q;
    done_d      = '0;

    unique case (state_q)
      IDLE: begin
        if (|gnt) begin
          state_d  = ACCESS;
          count_d  = CntInit;
          acc_id_d = oh_to_idx(gnt);
          if (gnt[PORT_DATA]) begin
            acc_we_d    = we[PORT_DATA];
            acc_addr_d  = addr_d;
            acc_wdata_d = wdata_d;
          end else if (gnt[PORT_DBG]) begin
            acc_we_d    = we[PORT_DBG];
            acc_addr_d  = addr_g;
            acc_wdata_d = wdata_g;
          end else begin
            acc_we_d    = 1'b0;
            acc_addr_d  = addr_f;
            acc_wdata_d = '0;
          end
        end
      end
      ACCESS: begin
        if (count_q == 4'd0) begin
          state_d = IDLE;
          done_d  = idx_to_oh(acc_id_q);
          if (!acc_we_q) begin
            rdata_d = mem_rdata;
          end
        end else begin
          count_d = count_q - 4'd1;
        end
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q     <= IDLE;
      count_q     <= '0;
      acc_id_q    <= '0;
      acc_we_q    <= 1'b0;
      acc_addr_q  <= '0;
      acc_wdata_q <= '0;
      rdata_q     <= '0;
      done_q      <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      acc_id_q    <= acc_id_d;
      acc_we_q    <= acc_we_d;
      acc_addr_q  <= acc_addr_d;
      acc_wdata_q <= acc_wdata_d;
      rdata_q     <= rdata_d;
      done_q      <= done_d;
    end
  end

  assign busy      = (state_q == ACCESS);
  assign mem_cs    = busy;
  assign mem_rd    = busy & ~acc_we_q;
  assign mem_wr    = busy & acc_we_q;
  assign mem_addr  = acc_addr_q;
  assign mem_wdata = acc_wdata_q;
  assign rdata     = rdata_q;
  assign done      = done_q;

endmodule
